// File: rtl/dmem_ram_bridge.sv
// dmem_ram_bridge: core data-memory port to a single-port, 64-bit-word RAM with
// combinational read. Handles byte/half/word/double accesses at any byte offset.
// Optional macro MISALIGN_SPLIT_EN: accesses that cross an 8-byte boundary are
// split into two RAM beats; without it only the first word is touched and
// misalign_err pulses.
module dmem_ram_bridge #(
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned IDX_W     = 28
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [63:0]      cmd_addr,
    input  logic             cmd_wen,
    input  logic [63:0]      cmd_wdata,
    input  logic [2:0]       cmd_size,
    output logic             rsp_valid,
    output logic [63:0]      rsp_data,
    output logic             misalign_err,
    output logic             ram_en,
    output logic [IDX_W-1:0] ram_idx,
    output logic             ram_wen,
    output logic [63:0]      ram_wdata,
    output logic [63:0]      ram_wmask,
    input  logic [63:0]      ram_rdata
);

`ifdef MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    // Expand an 8-bit byte-lane mask to a 64-bit bit mask.
    function automatic logic [63:0] f_expand(input logic [7:0] bm);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{bm[i]}};
        end
        return m;
    endfunction

    state_t            r_state;
    logic [2:0]        r_off;
    logic [3:0]        r_nb;
    logic              r_wen;
    logic [63:0]       r_wdata;
    logic [IDX_W-1:0]  r_word;
    logic              r_cross;
    logic [63:0]       r_result;

    state_t            w_state_nxt;
    logic              w_accept;
    logic [63:0]       w_result_nxt;
    logic              w_ram_en_nxt;
    logic              w_ram_wen_nxt;
    logic [IDX_W-1:0]  w_ram_idx_nxt;
    logic [63:0]       w_ram_wdata_nxt;
    logic [7:0]        w_ram_bmask_nxt;
    logic              w_rsp_valid_nxt;
    logic [63:0]       w_rsp_data_nxt;
    logic              w_mis_nxt;

    // Request decode straight from the command inputs (first beat issues on accept).
    logic [1:0]        w_acc_sz;
    logic [2:0]        w_acc_off;
    logic [3:0]        w_acc_nb;
    logic [IDX_W-1:0]  w_acc_word;
    logic              w_acc_cross;
    logic [7:0]        w_acc_bmask;
    logic [63:0]       w_acc_wdata;

    assign w_acc_sz    = (cmd_size > 3'd3) ? 2'd3 : cmd_size[1:0];
    assign w_acc_off   = cmd_addr[2:0];
    assign w_acc_nb    = 4'd1 << w_acc_sz;
    assign w_acc_word  = IDX_W'((cmd_addr - BASE_ADDR) >> 3);
    assign w_acc_cross = ({1'b0, w_acc_off} + w_acc_nb) > 4'd8;
    assign w_acc_bmask = 8'(((16'd1 << w_acc_nb) - 16'd1) << w_acc_off);
    assign w_acc_wdata = cmd_wdata << {w_acc_off, 3'b000};

    // Second-beat values and load assembly from the latched request.
    logic [IDX_W-1:0]  w_b1_idx;
    logic [5:0]        w_b1_sh;
    logic [3:0]        w_b1_cnt;
    logic [7:0]        w_b1_bmask;
    logic [63:0]       w_b1_wdata;
    logic [63:0]       w_b0_rd;
    logic [63:0]       w_b1_rd;
    logic [63:0]       w_nmask;

    assign w_b1_idx   = r_word + IDX_W'(1);
    assign w_b1_sh    = 6'({(4'd8 - {1'b0, r_off}), 3'b000});
    assign w_b1_cnt   = {1'b0, r_off} + r_nb - 4'd8;
    assign w_b1_bmask = 8'((16'd1 << w_b1_cnt) - 16'd1);
    assign w_b1_wdata = r_wdata >> w_b1_sh;
    assign w_b0_rd    = ram_rdata >> {r_off, 3'b000};
    assign w_b1_rd    = r_result | (ram_rdata << w_b1_sh);
    assign w_nmask    = f_expand(8'((16'd1 << r_nb) - 16'd1));

    // Next state and next values of the registered outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = 1'b0;
        w_result_nxt    = r_result;
        w_ram_en_nxt    = 1'b0;
        w_ram_wen_nxt   = 1'b0;
        w_ram_idx_nxt   = '0;
        w_ram_wdata_nxt = '0;
        w_ram_bmask_nxt = '0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = rsp_data;
        w_mis_nxt       = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_accept        = 1'b1;
                    w_state_nxt     = BEAT0;
                    w_ram_en_nxt    = 1'b1;
                    w_ram_wen_nxt   = cmd_wen;
                    w_ram_idx_nxt   = w_acc_word;
                    w_ram_wdata_nxt = w_acc_wdata;
                    w_ram_bmask_nxt = w_acc_bmask;
                end
            end
            BEAT0: begin
                if (!r_wen) begin
                    w_result_nxt = w_b0_rd;
                end
                w_mis_nxt = r_cross && !SPLIT_EN;
                if (r_cross && SPLIT_EN) begin
                    w_state_nxt     = BEAT1;
                    w_ram_en_nxt    = 1'b1;
                    w_ram_wen_nxt   = r_wen;
                    w_ram_idx_nxt   = w_b1_idx;
                    w_ram_wdata_nxt = w_b1_wdata;
                    w_ram_bmask_nxt = w_b1_bmask;
                end else if (r_wen) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt     = RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = w_b0_rd & w_nmask;
                end
            end
            BEAT1: begin
                if (r_wen) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_result_nxt    = w_b1_rd;
                    w_state_nxt     = RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = w_b1_rd & w_nmask;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, request latch and output registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_off        <= '0;
            r_nb         <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_word       <= '0;
            r_cross      <= 1'b0;
            r_result     <= '0;
            cmd_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            misalign_err <= 1'b0;
            ram_en       <= 1'b0;
            ram_wen      <= 1'b0;
            ram_idx      <= '0;
            ram_wdata    <= '0;
            ram_wmask    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_result     <= w_result_nxt;
            cmd_ready    <= (w_state_nxt == IDLE);
            rsp_valid    <= w_rsp_valid_nxt;
            rsp_data     <= w_rsp_data_nxt;
            misalign_err <= w_mis_nxt;
            ram_en       <= w_ram_en_nxt;
            ram_wen      <= w_ram_wen_nxt;
            ram_idx      <= w_ram_idx_nxt;
            ram_wdata    <= w_ram_wdata_nxt;
            ram_wmask    <= f_expand(w_ram_bmask_nxt);
            if (w_accept) begin
                r_off   <= w_acc_off;
                r_nb    <= w_acc_nb;
                r_wen   <= cmd_wen;
                r_wdata <= cmd_wdata;
                r_word  <= w_acc_word;
                r_cross <= w_acc_cross;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ram_bridge.sv
// Bench for dmem_ram_bridge: directed scenarios plus randomized traffic checked
// against a byte-addressed memory model. Honours MISALIGN_SPLIT_EN if defined.
`timescale 1ns/1ps
module tb_dmem_ram_bridge;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int unsigned IDX_W = 28;
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [63:0]      cmd_addr;
    logic             cmd_wen;
    logic [63:0]      cmd_wdata;
    logic [2:0]       cmd_size;
    logic             rsp_valid;
    logic [63:0]      rsp_data;
    logic             misalign_err;
    logic             ram_en;
    logic [IDX_W-1:0] ram_idx;
    logic             ram_wen;
    logic [63:0]      ram_wdata;
    logic [63:0]      ram_wmask;
    logic [63:0]      ram_rdata;

    dmem_ram_bridge #(.BASE_ADDR(BASE), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wen(cmd_wen), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .misalign_err(misalign_err),
        .ram_en(ram_en), .ram_idx(ram_idx), .ram_wen(ram_wen),
        .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    // RAM: 16 words, index aliased on low 4 bits; preload port for the bench.
    logic [63:0] tb_mem [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [63:0] pl_data = '0;
    always_comb ram_rdata = tb_mem[ram_idx[3:0]];
    always @(posedge clock) begin
        if (pl_en) tb_mem[pl_idx] <= pl_data;
        else if (ram_en && ram_wen)
            tb_mem[ram_idx[3:0]] <= (tb_mem[ram_idx[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
    end

    // Reference: flat byte memory, byte address = (addr - BASE) mod 128.
    logic [7:0] ref_mem [128];
    int total = 0;
    int bad   = 0;

    int               exp_beats, exp_mis, exp_rsp_cnt, exp_rsp_cyc, exp_ready;
    bit               exp_cross;
    logic [IDX_W-1:0] exp_idx0, exp_idx1;
    logic [63:0]      exp_data;
    logic [63:0]      exp_last_rsp = '0;

    int               ob_beats, ob_mis_cnt, ob_rsp_cnt, ob_rsp_cyc, ob_ready_cyc;
    bit               ob_timeout;
    logic [IDX_W-1:0] ob_idx   [2];
    logic             ob_wen   [2];
    logic [63:0]      ob_wdata [2];
    logic [63:0]      ob_wmask [2];
    logic [63:0]      ob_rsp_data;

    task automatic preload(input int w, input logic [63:0] d);
        pl_en = 1'b1; pl_idx = 4'(w); pl_data = d;
        @(negedge clock);
        pl_en = 1'b0;
        for (int i = 0; i < 8; i++) ref_mem[7'(w * 8 + i)] = d[8*i +: 8];
    endtask

    // Byte-level behaviour of one access: updates ref_mem and sets expectations.
    task automatic model_txn(input logic [63:0] a, input logic we, input logic [63:0] wd,
                             input logic [2:0] sz);
        int off, n, nacc;
        logic [63:0] rel;
        logic [6:0]  b;
        off = int'(a[2:0]);
        n = (sz >= 3'd3) ? 8 : (1 << sz);
        exp_cross = (off + n) > 8;
        nacc = (exp_cross && !SPLIT) ? 8 - off : n;
        rel = a - BASE;
        exp_idx0 = IDX_W'(rel >> 3);
        exp_idx1 = exp_idx0 + IDX_W'(1);
        exp_beats = (exp_cross && SPLIT) ? 2 : 1;
        exp_mis = (exp_cross && !SPLIT) ? 1 : 0;
        exp_rsp_cnt = we ? 0 : 1;
        exp_rsp_cyc = we ? -1 : exp_beats + 1;
        exp_ready = we ? exp_beats + 1 : exp_beats + 2;
        exp_data = '0;
        for (int i = 0; i < nacc; i++) begin
            b = 7'(rel[6:0] + 7'(i));
            if (we) ref_mem[b] = wd[8*i +: 8];
            else    exp_data[8*i +: 8] = ref_mem[b];
        end
        if (!we) exp_last_rsp = exp_data;
    endtask

    // Issue one request at a negedge with cmd_ready high and record what the DUT does.
    // Cycle k = k-th negedge after the accept edge. junk keeps cmd_valid high with
    // other contents while the bridge is busy.
    task automatic run_txn(input logic [63:0] a, input logic we, input logic [63:0] wd,
                           input logic [2:0] sz, input bit junk);
        int cyc;
        ob_beats = 0; ob_mis_cnt = 0; ob_rsp_cnt = 0; ob_rsp_cyc = -1;
        ob_ready_cyc = -1; ob_timeout = 1'b0; ob_rsp_data = '0;
        for (int i = 0; i < 2; i++) begin
            ob_idx[i] = '0; ob_wen[i] = 1'b0; ob_wdata[i] = '0; ob_wmask[i] = '0;
        end
        cmd_valid = 1'b1; cmd_addr = a; cmd_wen = we; cmd_wdata = wd; cmd_size = sz;
        @(negedge clock);
        if (junk) begin
            cmd_addr = BASE + 64'($urandom_range(0, 127));
            cmd_wen = ~we;
            cmd_wdata = {$urandom, $urandom};
            cmd_size = 3'($urandom_range(0, 7));
        end else begin
            cmd_valid = 1'b0;
        end
        cyc = 1;
        forever begin
            if (ram_en) begin
                if (ob_beats < 2) begin
                    ob_idx[ob_beats] = ram_idx; ob_wen[ob_beats] = ram_wen;
                    ob_wdata[ob_beats] = ram_wdata; ob_wmask[ob_beats] = ram_wmask;
                end
                ob_beats++;
            end
            if (rsp_valid) begin
                ob_rsp_cnt++; ob_rsp_cyc = cyc; ob_rsp_data = rsp_data;
            end
            if (misalign_err) ob_mis_cnt++;
            if (cmd_ready) begin
                ob_ready_cyc = cyc; cmd_valid = 1'b0;
                break;
            end
            if (cyc >= 8) begin
                ob_timeout = 1'b1; cmd_valid = 1'b0;
                break;
            end
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_wen = 1'b0;
        cmd_wdata = '0; cmd_size = '0;
        repeat (2) @(negedge clock);
        total++;
        if ({rsp_valid, misalign_err, ram_en, ram_wen} !== 4'b0) begin
            bad++; $display("FAIL reset_ctl got=%b exp=0000", {rsp_valid, misalign_err, ram_en, ram_wen});
        end
        total++;
        if (rsp_data !== 64'h0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        total++;
        if (ram_idx !== '0) begin bad++; $display("FAIL reset_ram_idx got=%h exp=0", ram_idx); end
        total++;
        if ((ram_wdata | ram_wmask) !== 64'h0) begin
            bad++; $display("FAIL reset_ram_data got=%h/%h exp=0", ram_wdata, ram_wmask);
        end
        for (int w = 0; w < 16; w++) preload(w, {$urandom, $urandom});
        reset_n = 1'b1;
        @(negedge clock);
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_aligned_load();
        preload(2, 64'h1122334455667788);
        model_txn(BASE + 64'h10, 1'b0, '0, 3'd3);
        run_txn(BASE + 64'h10, 1'b0, '0, 3'd3, 1'b0);
        total++;
        if (ob_beats != 1 || ob_idx[0] !== IDX_W'(2) || ob_wen[0] !== 1'b0) begin
            bad++; $display("FAIL aload_beat got beats=%0d idx=%0h wen=%b exp 1/2/0", ob_beats, ob_idx[0], ob_wen[0]);
        end
        total++;
        if (ob_rsp_cyc != 2 || ob_rsp_cnt != 1) begin
            bad++; $display("FAIL aload_latency got cyc=%0d cnt=%0d exp 2/1", ob_rsp_cyc, ob_rsp_cnt);
        end
        total++;
        if (ob_rsp_data !== 64'h1122334455667788) begin
            bad++; $display("FAIL aload_data got=%h exp=1122334455667788", ob_rsp_data);
        end
    endtask

    task automatic test_byte_store();
        model_txn(BASE + 64'h5, 1'b1, 64'hAB, 3'd0);
        run_txn(BASE + 64'h5, 1'b1, 64'hAB, 3'd0, 1'b0);
        total++;
        if (ob_beats != 1 || ob_idx[0] !== '0 || ob_wen[0] !== 1'b1) begin
            bad++; $display("FAIL bstore_beat got beats=%0d idx=%0h wen=%b exp 1/0/1", ob_beats, ob_idx[0], ob_wen[0]);
        end
        total++;
        if (ob_wmask[0] !== 64'h0000_FF00_0000_0000 || ob_wdata[0][47:40] !== 8'hAB) begin
            bad++; $display("FAIL bstore_lane got mask=%h wdata=%h exp mask=0000ff0000000000 byte5=ab", ob_wmask[0], ob_wdata[0]);
        end
        total++;
        if (ob_rsp_cnt != 0 || ob_ready_cyc != 2) begin
            bad++; $display("FAIL bstore_done got rsp=%0d ready=%0d exp 0/2", ob_rsp_cnt, ob_ready_cyc);
        end
    endtask

    task automatic test_crossing();
        preload(0, 64'hAABB_0000_0000_0000);
        preload(1, 64'h0000_0000_0000_CCDD);
        model_txn(BASE + 64'h6, 1'b0, '0, 3'd2);
        run_txn(BASE + 64'h6, 1'b0, '0, 3'd2, 1'b0);
`ifdef MISALIGN_SPLIT_EN
        total++;
        if (ob_beats != 2 || ob_idx[0] !== '0 || ob_idx[1] !== IDX_W'(1)) begin
            bad++; $display("FAIL xload_beats got n=%0d idx=%0h,%0h exp 2/0,1", ob_beats, ob_idx[0], ob_idx[1]);
        end
        total++;
        if (ob_rsp_data !== 64'hCCDDAABB || ob_mis_cnt != 0 || ob_rsp_cyc != 3) begin
            bad++; $display("FAIL xload_data got=%h mis=%0d cyc=%0d exp ccddaabb/0/3", ob_rsp_data, ob_mis_cnt, ob_rsp_cyc);
        end
        model_txn(BASE + 64'h7, 1'b1, 64'h1234, 3'd1);
        run_txn(BASE + 64'h7, 1'b1, 64'h1234, 3'd1, 1'b0);
        total++;
        if (ob_beats != 2 || ob_wmask[0] !== 64'hFF00_0000_0000_0000 || ob_wmask[1] !== 64'hFF ||
            ob_wdata[0][63:56] !== 8'h34 || ob_wdata[1][7:0] !== 8'h12) begin
            bad++; $display("FAIL xstore_split got n=%0d m0=%h m1=%h d0=%h d1=%h", ob_beats, ob_wmask[0], ob_wmask[1], ob_wdata[0], ob_wdata[1]);
        end
        total++;
        if (ob_mis_cnt != 0 || ob_ready_cyc != 3) begin
            bad++; $display("FAIL xstore_done got mis=%0d ready=%0d exp 0/3", ob_mis_cnt, ob_ready_cyc);
        end
`else
        total++;
        if (ob_beats != 1 || ob_idx[0] !== '0) begin
            bad++; $display("FAIL xload_beats got n=%0d idx=%0h exp 1/0", ob_beats, ob_idx[0]);
        end
        total++;
        if (ob_rsp_data !== 64'hAABB || ob_mis_cnt != 1 || ob_rsp_cyc != 2) begin
            bad++; $display("FAIL xload_data got=%h mis=%0d cyc=%0d exp aabb/1/2", ob_rsp_data, ob_mis_cnt, ob_rsp_cyc);
        end
        model_txn(BASE + 64'h7, 1'b1, 64'h1234, 3'd1);
        run_txn(BASE + 64'h7, 1'b1, 64'h1234, 3'd1, 1'b0);
        total++;
        if (ob_beats != 1 || ob_wmask[0] !== 64'hFF00_0000_0000_0000 || ob_wdata[0][63:56] !== 8'h34) begin
            bad++; $display("FAIL xstore_beat got n=%0d m0=%h d0=%h exp 1/ff00000000000000/34", ob_beats, ob_wmask[0], ob_wdata[0]);
        end
        total++;
        if (ob_mis_cnt != 1 || ob_ready_cyc != 2) begin
            bad++; $display("FAIL xstore_done got mis=%0d ready=%0d exp 1/2", ob_mis_cnt, ob_ready_cyc);
        end
`endif
    endtask

    // Crossing double at the top word of the index space; size 5 aliases to double.
    task automatic test_wrap();
        logic [63:0] a, wd;
        a = BASE - 64'h4;
        wd = {$urandom, $urandom};
        model_txn(a, 1'b1, wd, 3'd3);
        run_txn(a, 1'b1, wd, 3'd3, 1'b0);
        total++;
        if (ob_beats != exp_beats || ob_idx[0] !== exp_idx0) begin
            bad++; $display("FAIL wrap_beat0 got n=%0d idx=%0h exp %0d/%0h", ob_beats, ob_idx[0], exp_beats, exp_idx0);
        end
        if (exp_beats == 2) begin
            total++;
            if (ob_idx[1] !== '0) begin bad++; $display("FAIL wrap_idx1 got=%0h exp=0", ob_idx[1]); end
        end
        model_txn(a, 1'b0, '0, 3'd5);
        run_txn(a, 1'b0, '0, 3'd5, 1'b0);
        total++;
        if (ob_rsp_data !== exp_data || ob_rsp_cyc != exp_rsp_cyc) begin
            bad++; $display("FAIL wrap_load got=%h cyc=%0d exp=%h cyc=%0d", ob_rsp_data, ob_rsp_cyc, exp_data, exp_rsp_cyc);
        end
    endtask

    task automatic test_busy_ignore();
        model_txn(BASE + 64'h18, 1'b0, '0, 3'd3);
        run_txn(BASE + 64'h18, 1'b0, '0, 3'd3, 1'b1);
        total++;
        if (ob_beats != 1 || ob_idx[0] !== IDX_W'(3) || ob_rsp_data !== exp_data || ob_ready_cyc != 3) begin
            bad++; $display("FAIL busy_ignore got n=%0d idx=%0h data=%h ready=%0d exp 1/3/%h/3", ob_beats, ob_idx[0], ob_rsp_data, exp_data, ob_ready_cyc);
        end
        @(negedge clock);
        total++;
        if (ram_en !== 1'b0) begin bad++; $display("FAIL busy_no_accept got ram_en=%b exp=0", ram_en); end
    endtask

    task automatic test_random();
        logic [63:0] a, wd, w;
        logic        we;
        logic [2:0]  sz;
        int          mem_bad;
        for (int t = 0; t < 60; t++) begin
            a  = BASE + 64'($urandom_range(0, 127));
            we = 1'($urandom_range(0, 1));
            wd = {$urandom, $urandom};
            sz = 3'($urandom_range(0, 7));
            model_txn(a, we, wd, sz);
            run_txn(a, we, wd, sz, 1'($urandom_range(0, 1)));
            total++;
            if (ob_timeout || ob_ready_cyc != exp_ready) begin
                bad++; $display("FAIL rnd_ready t=%0d got=%0d exp=%0d", t, ob_ready_cyc, exp_ready);
            end
            total++;
            if (ob_beats != exp_beats || ob_idx[0] !== exp_idx0) begin
                bad++; $display("FAIL rnd_beats t=%0d got n=%0d idx=%0h exp %0d/%0h", t, ob_beats, ob_idx[0], exp_beats, exp_idx0);
            end
            if (exp_beats == 2) begin
                total++;
                if (ob_idx[1] !== exp_idx1) begin
                    bad++; $display("FAIL rnd_idx1 t=%0d got=%0h exp=%0h", t, ob_idx[1], exp_idx1);
                end
            end
            total++;
            if (ob_mis_cnt != exp_mis) begin
                bad++; $display("FAIL rnd_misalign t=%0d got=%0d exp=%0d", t, ob_mis_cnt, exp_mis);
            end
            total++;
            if (ob_rsp_cnt != exp_rsp_cnt || ob_rsp_cyc != exp_rsp_cyc) begin
                bad++; $display("FAIL rnd_rsp t=%0d got cnt=%0d cyc=%0d exp %0d/%0d", t, ob_rsp_cnt, ob_rsp_cyc, exp_rsp_cnt, exp_rsp_cyc);
            end
            if (!we) begin
                total++;
                if (ob_rsp_data !== exp_data) begin
                    bad++; $display("FAIL rnd_data t=%0d got=%h exp=%h", t, ob_rsp_data, exp_data);
                end
            end
            total++;
            if (rsp_data !== exp_last_rsp) begin
                bad++; $display("FAIL rnd_hold t=%0d got=%h exp=%h", t, rsp_data, exp_last_rsp);
            end
        end
        mem_bad = 0;
        for (int wi = 0; wi < 16; wi++) begin
            for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_mem[7'(wi * 8 + i)];
            if (tb_mem[wi] !== w) begin
                if (mem_bad == 0) $display("FAIL rnd_mem word=%0d got=%h exp=%h", wi, tb_mem[wi], w);
                mem_bad++;
            end
        end
        total++;
        if (mem_bad != 0) bad++;
    endtask

    task automatic test_reset_mid();
        int act;
        cmd_valid = 1'b1; cmd_addr = BASE + 64'h6; cmd_wen = 1'b0; cmd_size = 3'd2;
        @(negedge clock);
        cmd_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        total++;
        if ({ram_en, rsp_valid} !== 2'b00) begin
            bad++; $display("FAIL rstmid_abort got en/rsp=%b exp=00", {ram_en, rsp_valid});
        end
        reset_n = 1'b1;
        @(negedge clock);
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", cmd_ready); end
        act = 0;
        repeat (4) begin
            if (ram_en || rsp_valid) act++;
            @(negedge clock);
        end
        total++;
        if (act != 0) begin bad++; $display("FAIL rstmid_quiet got=%0d active cycles exp=0", act); end
    endtask

    initial begin
        test_reset();
        test_aligned_load();
        test_byte_store();
        test_crossing();
        test_wrap();
        test_busy_ignore();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_ram_bridge.md
DMEM_RAM_BRIDGE -- requirements
Module: dmem_ram_bridge

Interface
REQ-001 The parameter list SHALL be: BASE_ADDR, default 64'h8000_0000, physical address of RAM word 0.
REQ-002 The parameter list SHALL also include IDX_W, default 28, RAM word-index width.
REQ-003 Ports SHALL be as follows (clock and reset first):
- clock  in  1  sole clock; all state changes on posedge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  core request valid.
- cmd_ready  out  1  bridge can accept a request.
- cmd_addr  in  64  byte address.
- cmd_wen  in  1  1 = store, 0 = load.
- cmd_wdata  in  64  store data, LSB-justified.
- cmd_size  in  3  0 = byte, 1 = half, 2 = word, 3 = double.
- rsp_valid  out  1  load data valid, one-cycle pulse.
- rsp_data  out  64  load data, LSB-justified, zero-filled above size.
- misalign_err  out  1  one-cycle pulse: an access crossed an 8-byte boundary and was not split.
- ram_en  out  1  RAM access enable.
- ram_idx  out  IDX_W  64-bit word index.
- ram_wen  out  1  RAM write enable.
- ram_wdata  out  64  RAM write data.
- ram_wmask  out  64  bit-level write mask.
- ram_rdata  in  64  RAM read data, valid in the same cycle as ram_en (combinational read).

Function
REQ-004 The FSM SHALL have states IDLE, BEAT0, BEAT1 and RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-005 A request SHALL be accepted when cmd_valid and cmd_ready are both 1; addr, wen, wdata and size SHALL be latched; next state BEAT0.
REQ-006 Derived values SHALL be: off = addr[2:0]; n = 1<<min(size,3) bytes; crossing = (off+n > 8); word = (addr-BASE_ADDR)[IDX_W+2:3], modulo 2^IDX_W.
REQ-007 In BEAT0 the bridge SHALL drive:
- ram_en=1; ram_idx=word; ram_wen=wen.
- ram_wdata = wdata<<(8*off).
- Byte mask = (2^n-1)<<off, truncated to 8 bits; each byte bit expands to 8 mask bits.
- Load: byte lanes off..7 of ram_rdata captured into result bytes 0..(7-off).
REQ-008 BEAT1 (crossing only) SHALL drive:
- ram_idx = word+1, wrapping modulo 2^IDX_W.
- ram_wdata = wdata>>(8*(8-off)).
- Byte mask = low (off+n-8) bytes.
- Load: ram_rdata bytes 0..(off+n-9) captured into result bytes (8-off) upward.
REQ-009 The bridge SHALL drive ram_en=0, ram_wen=0 and ram_wmask=0 in IDLE and RESP.
REQ-010 From BEAT0: crossing and split enabled -> BEAT1; otherwise load -> RESP, store -> IDLE. From BEAT1: load -> RESP, store -> IDLE. From RESP -> IDLE.
REQ-011 In RESP, rsp_valid SHALL be 1 for exactly one cycle. rsp_data SHALL be the assembled result masked to n bytes and SHALL hold its value until the next RESP.
REQ-012 Stores SHALL produce no rsp_valid.
REQ-013 Latency from the accept edge SHALL be:
- Aligned load: rsp_valid 2 cycles later.
- Split load: rsp_valid 3 cycles later.
- Store: cmd_ready high again after 2 (aligned) or 3 (split) cycles.
REQ-014 cmd_size values 4-7 SHALL be treated as 3.
REQ-015 cmd_valid asserted outside IDLE SHALL be ignored and SHALL NOT be latched.

Reset
REQ-016 When reset_n is 0 at a posedge, the next state SHALL be IDLE, and the following outputs SHALL be 0: rsp_valid, rsp_data, misalign_err, ram_en, ram_wen, ram_idx, ram_wdata, ram_wmask.
REQ-017 Reset asserted during BEAT0, BEAT1 or RESP SHALL abort the access. No further RAM beat and no response SHALL follow.
REQ-018 cmd_ready SHALL be 1 in the first cycle after reset_n returns to 1.

Configuration
REQ-019 With MISALIGN_SPLIT_EN defined, crossing accesses SHALL use BEAT1 and misalign_err SHALL stay 0.
REQ-020 Without MISALIGN_SPLIT_EN, BEAT1 SHALL be unreachable. Only BEAT0 bytes SHALL be accessed, and misalign_err SHALL pulse for one cycle:
- Loads: in RESP.
- Stores: in the cycle after BEAT0.

Verification
REQ-021 Aligned load: load double at 0x8000_0010 with RAM word 2 = 0x1122334455667788 -> ram_idx=2 in BEAT0; rsp_valid 2 cycles after accept; rsp_data=0x1122334455667788.
REQ-022 Byte store: store byte 0xAB at 0x8000_0005 -> a single beat with ram_idx=0, byte mask 0x20, ram_wdata[47:40]=0xAB; rsp_valid stays 0.
REQ-023 Split load (macro on): load word at 0x8000_0006, word0=0xAABB_0000_0000_0000, word1=0x0000_0000_0000_CCDD -> beats at idx 0 then 1; rsp_data=0xCCDDAABB; misalign_err=0.
REQ-024 Crossing store (macro off): store half 0x1234 at 0x8000_0007 -> one beat, byte mask 0x80, ram_wdata[63:56]=0x34; misalign_err pulses once.
REQ-025 Reset mid-operation: reset_n low during BEAT0 of a split load -> no BEAT1 and no rsp_valid; cmd_ready=1 in the first cycle after release.
